conv1_ctrl: RTL
===============

// Module: conv1_ctrl
// PURPOSE
//  Frame sequencer for the conv1 stage. Accepts the raster-order pixel stream (one 28x28 frame per start).
//  Drives the shift enable of the 5x5 window line buffer. Tracks row/column position.
//  Asserts valid_out_buf only when the window holds a full 5x5 patch; valid_out_buf feeds the conv1 sum/bias datapath.
//  Reports busy, done, output coordinates and protocol errors to the top-level CNN controller.
// PARAMETERS
//  WIDTH        28  pixels per input row
//  HEIGHT       28  rows per input frame
//  FILTER_SIZE   5  kernel side; window valid once FILTER_SIZE-1 rows/cols are buffered
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   1-cycle pulse: arm for a new frame (ignored unless IDLE)
//  valid_in       in   1   pixel present on line-buffer input this cycle
//  buf_shift_en   out  1   combinational: valid_in && state==ACTIVE; shifts line buffer
//  valid_out_buf  out  1   registered: window at (out_row,out_col) is complete
//  out_row        out  5   output-map row, 0..HEIGHT-FILTER_SIZE (registered with valid_out_buf)
//  out_col        out  5   output-map col, 0..WIDTH-FILTER_SIZE (registered with valid_out_buf)
//  busy           out  1   high in ACTIVE
//  frame_done     out  1   1-cycle pulse after final window of frame
//  err_overrun    out  1   sticky: valid_in seen while not ACTIVE; cleared by start
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE; all outputs 0; counters row/col=0.
//  FSM: IDLE -> ACTIVE on start.
//   - ACTIVE -> DONE on accepted pixel with row==HEIGHT-1 && col==WIDTH-1.
//   - DONE -> IDLE unconditionally next cycle.
//  Counters:
//   - advance only on valid_in in ACTIVE.
//   - col wraps WIDTH-1 -> 0; row increments on col wrap.
//   - Both cleared on start and on entering DONE.
//   - Counter widths: $clog2(WIDTH), $clog2(HEIGHT); out_row/out_col declared 5 bits for defaults.
//  Window valid, 1-cycle latency from accepted pixel:
//   - Condition: row>=FILTER_SIZE-1 && col>=FILTER_SIZE-1.
//   - Registered result: valid_out_buf=1, out_row=row-(FILTER_SIZE-1), out_col=col-(FILTER_SIZE-1).
//   - Otherwise valid_out_buf=0 and out_row/out_col hold their last values.
//   - Gaps in valid_in stall counting; no window is emitted without a new pixel.
//  Edge columns:
//   - Pixels col<FILTER_SIZE-1 shift the buffer but produce no valid.
//   - The row wrap never creates a straddling window.
//  frame_done:
//   - High in DONE, i.e. same cycle as last valid_out_buf (out_row=out_col=23).
//   - Exactly (WIDTH-FILTER_SIZE+1)*(HEIGHT-FILTER_SIZE+1)=576 valids per frame.
//  busy=1 only in ACTIVE; start while ACTIVE or DONE is ignored (no counter reset).
//  valid_in outside ACTIVE: no shift, no count, err_overrun set (sticky) next cycle.
//  Simultaneous start and valid_in in IDLE: start wins; that pixel is not accepted, err_overrun set.
//  Async reset mid-frame:
//   - Immediate return to IDLE; no frame_done.
//   - Next start begins a clean frame at (0,0).
// TESTING
//  1 Reset, start, 784 back-to-back valid_in -> 576 valid_out_buf.
//    First valid at pixel 116 (row4,col4) with out=(0,0), 1 cycle later; frame_done with out=(23,23).
//  2 Same frame, valid_in randomly deasserted ~30% -> identical (out_row,out_col) sequence, 576 valids.
//    No valid in any cycle without a preceding accepted pixel.
//  3 Row boundary: pixels col 0..3 of rows 4..27 -> no valid_out_buf.
//    col 4 -> out_col=0; col 27 -> out_col=23.
//  4 valid_in with no start -> buf_shift_en=0, err_overrun=1.
//    A following start clears err_overrun, busy=1.
//  5 start pulsed at pixel 300 of frame -> ignored; frame completes at pixel 784 normally.
//  6 rst_n low at pixel 400 -> outputs 0 asynchronously.
//    New start + 784 pixels -> 576 valids, counts from (0,0).

Source files
------------

// File: rtl/conv1_ctrl_if.sv
// Handshake and status bundle between the conv1 frame sequencer and its environment.
// The master drives the pixel stream and start, and the slave (conv1_ctrl) reports window and frame status.
interface conv1_ctrl_if;
  logic       start;
  logic       valid_in;
  logic       buf_shift_en;
  logic       valid_out_buf;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       busy;
  logic       frame_done;
  logic       err_overrun;

  modport master (
    output start, valid_in,
    input  buf_shift_en, valid_out_buf, out_row, out_col, busy, frame_done, err_overrun
  );

  modport slave (
    input  start, valid_in,
    output buf_shift_en, valid_out_buf, out_row, out_col, busy, frame_done, err_overrun
  );
endinterface

// File: rtl/conv1_ctrl.sv
// conv1 frame sequencer.
// Counts raster position over one frame and drives the line-buffer shift.
// Flags each complete FILTER_SIZE x FILTER_SIZE window, together with its output-map coordinate.
module conv1_ctrl #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned HEIGHT      = 28,
  parameter int unsigned FILTER_SIZE = 5
) (
  input logic        clk,
  input logic        rst_n,
  conv1_ctrl_if.slave bus_io
);

  localparam int unsigned ColW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned Edge = FILTER_SIZE - 1;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e          state_q;
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic            valid_q;
  logic [4:0]      out_row_q;
  logic [4:0]      out_col_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic accept;
  logic col_last;
  logic win_full;
  logic frame_last;

  // Decode the pixel acceptance, wrap and window-complete conditions from the current position.
  always_comb begin
    accept     = bus_io.valid_in && (state_q == StActive);
    col_last   = (col_q == ColW'(WIDTH - 1));
    win_full   = (row_q >= RowW'(Edge)) && (col_q >= ColW'(Edge));
    frame_last = col_last && (row_q == RowW'(HEIGHT - 1));
  end

  // Frame FSM, position counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;

      // A stray pixel outranks a same-cycle start, so the error survives that start.
      if (bus_io.valid_in && (state_q != StActive)) begin
        err_q <= 1'b1;
      end else if (bus_io.start && (state_q == StIdle)) begin
        err_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q <= StActive;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        StActive: begin
          if (accept) begin
            if (win_full) begin
              valid_q   <= 1'b1;
              out_row_q <= 5'(row_q - RowW'(Edge));
              out_col_q <= 5'(col_q - ColW'(Edge));
            end
            if (frame_last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              col_q   <= '0;
              row_q   <= '0;
            end else if (col_last) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.buf_shift_en  = accept;
  assign bus_io.valid_out_buf = valid_q;
  assign bus_io.out_row       = out_row_q;
  assign bus_io.out_col       = out_col_q;
  assign bus_io.busy          = busy_q;
  assign bus_io.frame_done    = done_q;
  assign bus_io.err_overrun   = err_q;

endmodule
